// File: rtl/channel_count_serializer_if.sv
// Bundle between the channel-sequencing FSM and the count/readout stage:
// impulse inputs, channel select and strobes in, serial word and status out.
interface channel_count_serializer_if #(
  parameter int NCH = 10
);
  logic [NCH-1:0] imp_in;
  logic [3:0]     ch_addr;
  logic           sl;
  logic           out_rst;
  logic           sdo;
  logic           sdo_valid;
  logic           ovf;
  logic           busy;

  modport master (
    output imp_in, ch_addr, sl, out_rst,
    input  sdo, sdo_valid, ovf, busy
  );

  modport slave (
    input  imp_in, ch_addr, sl, out_rst,
    output sdo, sdo_valid, ovf, busy
  );
endinterface

// File: rtl/channel_count_serializer.sv
// Per-channel saturating impulse counters with a snapshot-and-shift readout.
// A word takes CW cycles of MSB-first data plus one ovf cycle; sl is ignored while busy.
module channel_count_serializer #(
  parameter int NCH = 10,
  parameter int CW  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  channel_count_serializer_if.slave bus
);
  localparam int BW = (CW > 1) ? $clog2(CW) : 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] prev;
  logic [NCH-1:0] edge_det;
  logic [CW-1:0]  cnt [NCH];
  logic [CW-1:0]  shreg;
  logic [CW-1:0]  snap;
  logic [BW-1:0]  bitcnt;
  logic           load;

  assign edge_det = sync2 & ~prev;
  assign load     = (state == IDLE) && bus.sl;

  // Out-of-range addresses match no channel, so they read as zero and clear nothing.
  always_comb begin
    snap = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.ch_addr == 4'(i)) snap = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= bus.imp_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // An edge coinciding with the load of its own channel opens the next count period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.out_rst) begin
          cnt[i] <= '0;
        end else if (load && (bus.ch_addr == 4'(i))) begin
          cnt[i] <= edge_det[i] ? CW'(1) : '0;
        end else if (edge_det[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.sl) state_nxt = SHIFT;
      SHIFT:   if (bitcnt == BW'(CW - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (load) begin
      shreg  <= snap;
      bitcnt <= '0;
    end else if (state == SHIFT) begin
      shreg  <= shreg << 1;
      bitcnt <= bitcnt + BW'(1);
    end
  end

  // Outputs decode the state register only, so an async reset drops them at once.
  assign bus.sdo       = (state == SHIFT) && shreg[CW-1];
  assign bus.sdo_valid = (state == SHIFT);
  assign bus.ovf       = (state == DONE);
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_channel_count_serializer.sv
// Directed and randomized checks of the count/readout stage against a
// per-channel pulse-count model with serial word reconstruction.
module tb_channel_count_serializer;
  localparam int NCH = 10;
  localparam int CW  = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   model [NCH];

  channel_count_serializer_if #(.NCH(NCH)) bus ();

  channel_count_serializer #(.NCH(NCH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse every channel in mask: 2 cycles high, 2 cycles low.
  task automatic pulse(input logic [NCH-1:0] mask);
    bus.imp_in = mask;
    @(negedge clk);
    @(negedge clk);
    bus.imp_in = '0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NCH; i++)
      if (mask[i] && model[i] < MAXV) model[i]++;
  endtask

  task automatic pulse_n(input int ch, input int n);
    for (int k = 0; k < n; k++) pulse(NCH'(1) << ch);
  endtask

  task automatic clear_all();
    bus.out_rst = 1'b1;
    @(negedge clk);
    bus.out_rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NCH; i++) model[i] = 0;
  endtask

  // Starts and ends on a negedge. Optionally asserts out_rst with sl, or injects
  // a second sl at data bit inj_at.
  task automatic read_word(input int addr, input bit with_rst, input int inj_at,
                           input int inj_addr, input string tag);
    logic [CW-1:0] word;
    int expv;
    expv = (addr < NCH) ? model[addr] : 0;
    bus.ch_addr = 4'(addr);
    bus.sl      = 1'b1;
    bus.out_rst = with_rst;
    @(negedge clk);
    bus.sl      = 1'b0;
    bus.out_rst = 1'b0;
    bus.ch_addr = 4'($urandom_range(0, 15));
    word = '0;
    for (int b = 0; b < CW; b++) begin
      check({tag, " sdo_valid"}, 32'(bus.sdo_valid), 32'd1);
      word = {word[CW-2:0], bus.sdo};
      if (b == inj_at) begin
        bus.sl      = 1'b1;
        bus.ch_addr = 4'(inj_addr);
      end
      @(negedge clk);
      bus.sl = 1'b0;
    end
    check({tag, " word"}, 32'(word), 32'(expv));
    check({tag, " ovf pulse"}, {bus.ovf, bus.sdo_valid, bus.sdo, bus.busy}, 32'b1001);
    @(negedge clk);
    check({tag, " idle after"}, {bus.ovf, bus.sdo_valid, bus.busy}, 32'b000);
    if (addr < NCH) model[addr] = 0;
    if (with_rst) for (int i = 0; i < NCH; i++) model[i] = 0;
  endtask

  initial begin
    int ovf_seen;
    int r;
    for (int i = 0; i < NCH; i++) model[i] = 0;
    bus.imp_in  = '0;
    bus.ch_addr = '0;
    bus.sl      = 1'b0;
    bus.out_rst = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", {bus.sdo, bus.sdo_valid, bus.ovf, bus.busy}, 32'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic five-pulse word, then the channel reads back empty.
    pulse_n(3, 5);
    read_word(3, 1'b0, -1, 0, "t1 ch3");
    read_word(3, 1'b0, -1, 0, "t1 ch3 cleared");

    // Saturation.
    pulse_n(0, 300);
    read_word(0, 1'b0, -1, 0, "t2 sat");
    read_word(0, 1'b0, -1, 0, "t2 after sat");

    // Edge coinciding with the load of ch2 belongs to the new period.
    pulse_n(2, 3);
    bus.imp_in = NCH'(1) << 2;
    @(negedge clk);
    @(negedge clk);
    read_word(2, 1'b0, -1, 0, "t3 coincide");
    model[2] = 1;
    bus.imp_in = '0;
    @(negedge clk);
    @(negedge clk);
    read_word(2, 1'b0, -1, 0, "t3 next");

    // sl while busy is ignored and clears nothing.
    pulse_n(5, 4);
    pulse_n(6, 6);
    read_word(5, 1'b0, 3, 6, "t4 busy sl");
    check("t4 no extra word", {bus.ovf, bus.sdo_valid, bus.busy}, 32'b000);
    read_word(6, 1'b0, -1, 0, "t4 target kept");

    // out_rst together with sl: pre-clear snapshot, then everything cleared.
    pulse_n(1, 7);
    pulse_n(4, 9);
    read_word(4, 1'b1, -1, 0, "t5 rst+sl");
    read_word(1, 1'b0, -1, 0, "t5 ch1 cleared");
    read_word(4, 1'b0, -1, 0, "t5 ch4 cleared");
    read_word(12, 1'b0, -1, 0, "t5 addr12");

    // Randomized mix of pulses, reads and clears.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6) pulse(NCH'($urandom));
      else if (r < 9) read_word($urandom_range(0, 15), 1'b0, -1, 0, "rand read");
      else clear_all();
    end
    for (int i = 0; i < NCH; i++) read_word(i, 1'b0, -1, 0, "rand final");

    // Async reset mid-word.
    pulse_n(7, 3);
    bus.ch_addr = 4'd7;
    bus.sl      = 1'b1;
    @(negedge clk);
    bus.sl = 1'b0;
    repeat (4) @(negedge clk);
    check("t6 mid-word valid", 32'(bus.sdo_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("t6 reset drop", {bus.sdo_valid, bus.busy, bus.ovf}, 32'b000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) model[i] = 0;
    ovf_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.ovf) ovf_seen++;
    end
    check("t6 no ovf after reset", 32'(ovf_seen), 32'd0);
    read_word(7, 1'b0, -1, 0, "t6 ch7 cleared");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/channel_count_serializer.md
Name: channel_count_serializer

Overview:
Counting and readout stage beside the channel-sequencing FSM. Counts rising edges on NCH synchronized impulse inputs. On each SL strobe it snapshots the channel selected by the FSM address and shifts the value out serially. When the word is finished it returns the ovf pulse that advances the FSM to its next channel.

Parameters:
NCH, 10, number of impulse channels; address values 0..NCH-1 are valid.
CW, 8, per-channel counter width and serial word length in bits.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
imp_in  input  NCH  raw asynchronous impulse inputs, one per channel.
ch_addr  input  4  channel select {a3,a2,a1,a0} from the sequencing FSM.
sl  input  1  load strobe from the FSM, one cycle wide.
out_rst  input  1  clear-all-counters request from the FSM.
sdo  output  1  serial data out, MSB first.
sdo_valid  output  1  high while sdo carries a valid bit.
ovf  output  1  one-cycle pulse at word completion; drives the FSM ovf input.
busy  output  1  high in SHIFT and DONE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all counters, synchronizers, edge registers, shift register and bit counter go to 0;
  - state = IDLE;
  - sdo=0, sdo_valid=0, ovf=0, busy=0.
- Input path, per channel:
  - 2-flop synchronizer, then a third flop for edge detect;
  - edge = sync & ~prev;
  - latency from imp_in rising to counter increment is 3 clk edges;
  - minimum detectable pulse width is 2 clk high plus 2 clk low.
- Counter rules:
  - edge: cnt <= cnt+1, saturating at 2^CW-1 (no wrap).
  - Load clear: the channel being loaded is cleared in the same cycle as the snapshot. If an edge for that channel occurs in the same cycle, cnt <= 1 (the edge belongs to the new period).
  - out_rst=1: all counters <= 0 next edge; edges in that cycle are dropped.
  - out_rst and sl in the same cycle: the snapshot takes the pre-clear value, then all counters clear.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on sl=1:
    - shreg <= cnt[ch_addr], or 0 if ch_addr >= NCH (nothing is cleared);
    - bitcnt <= 0; go to SHIFT.
  - IDLE: sl=0 means stay in IDLE.
  - SHIFT:
    - sdo = shreg[CW-1], sdo_valid=1;
    - each edge: shreg shifts left with 0 fill, bitcnt+1;
    - when bitcnt==CW-1, go to DONE.
  - DONE: ovf=1, sdo_valid=0, sdo=0; next edge go to IDLE.
  - Timing: with sl sampled at edge k, data bits are valid in cycles k..k+CW-1 and ovf is high in cycle k+CW. Total CW+1 cycles per word.
- sl while busy=1: ignored; no snapshot and no counter clear.
- out_rst during SHIFT/DONE: counters clear; the word in flight is unaffected.
- rst_n asserted mid-word: immediate return to IDLE; no ovf is produced.
- ch_addr is sampled only at the sl edge; later changes have no effect.

Test Plan:
1. Reset, then 5 pulses on imp_in[3]; ch_addr=3; sl 1 cycle -> sdo_valid high 8 cycles carrying 0000_0101 MSB first; ovf high exactly 1 cycle after the last bit; cnt[3]=0 afterwards.
2. 300 pulses on ch 0, then read ch 0 -> serial word 1111_1111 (saturation); a second read right after -> 0000_0000.
3. Pulse on ch 2 whose synchronized edge coincides with the sl load of ch 2 -> the loaded word excludes that pulse; the next read of ch 2 returns 1.
4. Second sl issued mid-word while busy=1 -> ignored: no extra sdo_valid cycles, exactly one ovf, and the target counter is not cleared.
5. Counts 7 and 9 on ch 1 and ch 4; out_rst and sl (ch_addr=4) in the same cycle -> word 0000_1001 shifted out; all counters 0 afterwards; ch_addr=12 read -> 0000_0000.
6. rst_n low at bit 4 of a word -> sdo_valid, busy and ovf drop to 0 immediately; no ovf pulse after release.
